// File: rtl/r22_fft_sched_pkg.sv
// Shared types and elaboration helpers for the radix-2^2 SDF FFT sequencer.
package r22_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Per-sample tag carried alongside the datapath.
    typedef struct packed {
        logic is_real;
        logic sop;
        logic eop;
    } tag_t;

    // Bits of a tag that describe frame position (cleared for orphaned samples).
    localparam logic [2:0] TAG_FRAME_BITS = 3'b011;

    function automatic int log4n(input int n);
        return $clog2(n) / 2;
    endfunction

    // Enable-cycle delay of a stage control bit: BFI at s*slat, BFII one butterfly later.
    function automatic int stage_dly(input int s, input int slat, input int bf_lat, input bit bfii);
        return s * slat + (bfii ? bf_lat : 0);
    endfunction

endpackage

// File: rtl/r22_fft_sched_if.sv
// Sample-in / result-out stream bundle of the FFT sequencer.
// Handshake: a sample transfers on a clock edge where s_valid and s_ready are
// both high; s_sop qualifies that sample only. m_* are result qualifiers with
// no back-pressure: m_valid marks a real result on the datapath output in that
// cycle, m_sop/m_eop are only meaningful while m_valid is high.
interface r22_fft_sched_if;
    import r22_fft_pkg::*;

    logic s_valid;
    logic s_sop;
    logic s_ready;
    logic m_valid;
    logic m_sop;
    logic m_eop;

    // master: sample source and result sink
    modport master (output s_valid, s_sop, input s_ready, m_valid, m_sop, m_eop);
    // slave: the sequencer
    modport slave  (input s_valid, s_sop, output s_ready, m_valid, m_sop, m_eop);

endinterface

// File: rtl/r22_fft_sched_en_delay.sv
// Enable-gated shift register; DEPTH 0 is a plain wire. An optional per-entry
// clear knocks CLR_MASK bits out of entries as they shift.
module r22_en_delay
    import r22_fft_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               DEPTH    = 1,
    parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [((DEPTH > 0) ? DEPTH : 1)-1:0] clr,
    input  logic [WIDTH-1:0]                     d,
    output logic [WIDTH-1:0]                     q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk, rst, en, clr};
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];

        // Shift on enable; clr[i] masks the entry landing in position i.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (en) begin
                sr[0] <= d & ~({WIDTH{clr[0]}} & CLR_MASK);
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1] & ~({WIDTH{clr[i]}} & CLR_MASK);
                end
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/r22_fft_sched.sv
// Radix-2^2 SDF FFT sequencer: point counter, global enable, delayed per-stage
// butterfly controls, sample tagging and zero-injection drain on flush.
module r22_fft_sched
    import r22_fft_pkg::*;
#(
    parameter  int N_POINTS = 16,
    parameter  int BF_LAT   = 1,
    parameter  int TFM_LAT  = 2,
    parameter  int PIPE_LAT = 18,
    localparam int LOG2N    = $clog2(N_POINTS),
    localparam int LOG4N    = log4n(N_POINTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    r22_fft_sched_if.slave       strm,
    input  logic                 flush,
    output logic                 fft_en,
    output logic                 in_zero,
    output logic [LOG2N-1:0]     ctrl_cnt,
    output logic [LOG4N-1:0]     ctrl_bfi,
    output logic [LOG4N-1:0]     ctrl_bfii1,
    output logic [LOG4N-1:0]     ctrl_bfii2,
    output logic [15:0]          frame_cnt,
    output logic                 err_sop,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam int SLAT = 2 * BF_LAT + TFM_LAT;
    localparam int DW   = $clog2(PIPE_LAT + 1);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    state_t            state, state_nx;
    logic              rdy, en, accept, resync, drain_done;
    logic [LOG2N-1:0]  cnt_q, eff_idx;
    logic              flush_q;
    logic [DW-1:0]     drain_q;
    logic [15:0]       frame_q;
    logic              err_q;
    tag_t              tag_in, tail;
    logic [2:0]        tail_bits;
    logic [PIPE_LAT-1:0] tag_clr;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state, ready, enable and input-mux select.
    always_comb begin
        state_nx = state;
        rdy      = 1'b1;
        en       = 1'b0;
        in_zero  = 1'b0;
        unique case (state)
            IDLE: begin
                en = strm.s_valid & strm.s_sop;
                if (en) state_nx = RUN;
            end
            RUN: begin
                en = strm.s_valid;
                if (flush_q && cnt_q == '0 && !strm.s_valid) state_nx = FLUSH;
            end
            FLUSH: begin
                rdy     = 1'b0;
                en      = 1'b1;
                in_zero = 1'b1;
                if (drain_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept     = strm.s_valid & rdy;
    assign drain_done = (drain_q == DW'(PIPE_LAT - 1));
    // An sop always restarts the frame at index 0; mid-frame it is an error.
    assign resync     = (state == RUN) & accept & strm.s_sop & (cnt_q != '0);
    assign eff_idx    = (accept & strm.s_sop) ? '0 : cnt_q;

    // Point counter: advances per enable, cleared when the drain finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    cnt_q <= '0;
        else if (state == FLUSH && drain_done)       cnt_q <= '0;
        else if (en)                                 cnt_q <= eff_idx + 1'b1;
    end

    // Flush latch (only armed while running), drain counter, frame counter, error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q <= 1'b0;
            drain_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == FLUSH && drain_done) flush_q <= 1'b0;
            else if (state == RUN && flush)   flush_q <= 1'b1;
            drain_q <= (state == FLUSH) ? drain_q + 1'b1 : '0;
            if (accept && eff_idx == LAST_IDX) frame_q <= frame_q + 16'd1;
            err_q <= resync;
        end
    end

    // Per-stage butterfly controls, each aligned to its stage's register latency.
    for (genvar s = 0; s < LOG4N; s++) begin : g_stage
        r22_en_delay #(.WIDTH(1), .DEPTH(stage_dly(s, SLAT, BF_LAT, 1'b0))) u_bfi (
            .clk(clk), .rst(rst), .en(en), .clr('0),
            .d(eff_idx[LOG2N-1-2*s]), .q(ctrl_bfi[s]));
        r22_en_delay #(.WIDTH(1), .DEPTH(stage_dly(s, SLAT, BF_LAT, 1'b1))) u_bfii1 (
            .clk(clk), .rst(rst), .en(en), .clr('0),
            .d(eff_idx[LOG2N-1-2*s]), .q(ctrl_bfii1[s]));
        r22_en_delay #(.WIDTH(1), .DEPTH(stage_dly(s, SLAT, BF_LAT, 1'b1))) u_bfii2 (
            .clk(clk), .rst(rst), .en(en), .clr('0),
            .d(eff_idx[LOG2N-2-2*s]), .q(ctrl_bfii2[s]));
    end

    // Tag entering the pipe; zero in FLUSH because nothing is accepted there.
    always_comb begin
        tag_in.is_real = accept;
        tag_in.sop     = accept & (eff_idx == '0);
        tag_in.eop     = accept & (eff_idx == LAST_IDX);
    end

    // On resync, the orphaned partial frame occupies entries 1..cnt after the shift.
    always_comb begin
        tag_clr = '0;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_clr[i] = resync & (i <= int'(cnt_q));
        end
    end

    r22_en_delay #(.WIDTH(3), .DEPTH(PIPE_LAT), .CLR_MASK(TAG_FRAME_BITS)) u_tag (
        .clk(clk), .rst(rst), .en(en), .clr(tag_clr),
        .d(tag_in), .q(tail_bits));

    assign tail         = tag_t'(tail_bits);
    assign strm.s_ready = rdy;
    assign strm.m_valid = en & tail.is_real;
    assign strm.m_sop   = en & tail.is_real & tail.sop;
    assign strm.m_eop   = en & tail.is_real & tail.eop;
    assign fft_en       = en;
    assign ctrl_cnt     = cnt_q;
    assign frame_cnt    = frame_q;
    assign err_sop      = err_q;
    assign busy         = (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_r22_fft_sched.sv
// Directed bench for r22_fft_sched (N=16, SLAT=4, PIPE_LAT=18).
module tb_r22_fft_sched;
    import r22_fft_pkg::*;

    localparam int N  = 16;
    localparam int PL = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    r22_fft_sched_if bus ();
    logic        fft_en, in_zero, err_sop, busy;
    logic [3:0]  ctrl_cnt;
    logic [1:0]  ctrl_bfi, ctrl_bfii1, ctrl_bfii2;
    logic [15:0] frame_cnt;
    state_t      dbg_state;

    r22_fft_sched dut (
        .clk(clk), .rst(rst), .strm(bus), .flush(flush),
        .fft_en(fft_en), .in_zero(in_zero), .ctrl_cnt(ctrl_cnt),
        .ctrl_bfi(ctrl_bfi), .ctrl_bfii1(ctrl_bfii1), .ctrl_bfii2(ctrl_bfii2),
        .frame_cnt(frame_cnt), .err_sop(err_sop), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int hist_idx[$];          // sample index pushed at each enable
    logic [2:0] exp_q[$];     // expected tag {real,sop,eop} pushed at each enable
    int mv_cnt = 0, ms_cnt = 0, me_cnt = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Base bit b of the index pushed d enables ago (0 before enough history).
    function automatic logic dly_bit(input int d, input int b);
        int n, t;
        n = hist_idx.size();
        if (n < d) return 1'b0;
        t = hist_idx[n-d];
        return t[b];
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle, check combinational outputs before the edge, update model,
    // return just after the edge so callers can check registered outputs.
    task automatic step(input logic v, input logic sop, input logic fl, input logic exp_en,
                        input int idx, input logic real_s, input int clr_n);
        logic [2:0] tail;
        logic [2:0] t;
        int n;
        @(negedge clk);
        bus.s_valid = v;
        bus.s_sop   = sop;
        flush       = fl;
        #2;
        n    = hist_idx.size();
        tail = (exp_en && n >= PL) ? exp_q[n-PL] : 3'b000;
        expect_eq("fft_en",  32'(fft_en),      32'(exp_en));
        expect_eq("m_valid", 32'(bus.m_valid), 32'(tail[2]));
        expect_eq("m_sop",   32'(bus.m_sop),   32'(tail[2] & tail[1]));
        expect_eq("m_eop",   32'(bus.m_eop),   32'(tail[2] & tail[0]));
        if (exp_en) expect_eq("bfi0", 32'(ctrl_bfi[0]), 32'((idx >> 3) & 1));
        expect_eq("bfii1_0", 32'(ctrl_bfii1[0]), 32'(dly_bit(1, 3)));
        expect_eq("bfii2_0", 32'(ctrl_bfii2[0]), 32'(dly_bit(1, 2)));
        expect_eq("bfi1",    32'(ctrl_bfi[1]),   32'(dly_bit(4, 1)));
        expect_eq("bfii1_1", 32'(ctrl_bfii1[1]), 32'(dly_bit(5, 1)));
        expect_eq("bfii2_1", 32'(ctrl_bfii2[1]), 32'(dly_bit(5, 0)));
        mv_cnt += int'(bus.m_valid);
        ms_cnt += int'(bus.m_sop);
        me_cnt += int'(bus.m_eop);
        if (exp_en) begin
            for (int k = 1; k <= clr_n; k++) begin
                t = exp_q[n-k];
                exp_q[n-k] = t & 3'b100;
            end
            hist_idx.push_back(idx);
            exp_q.push_back(real_s ? {1'b1, idx == 0, idx == N-1} : 3'b000);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        expect_eq({pfx, "_s_ready"},  32'(bus.s_ready), 32'd1);
        expect_eq({pfx, "_fft_en"},   32'(fft_en),      32'd0);
        expect_eq({pfx, "_in_zero"},  32'(in_zero),     32'd0);
        expect_eq({pfx, "_cnt"},      32'(ctrl_cnt),    32'd0);
        expect_eq({pfx, "_bfi"},      32'(ctrl_bfi),    32'd0);
        expect_eq({pfx, "_bfii1"},    32'(ctrl_bfii1),  32'd0);
        expect_eq({pfx, "_bfii2"},    32'(ctrl_bfii2),  32'd0);
        expect_eq({pfx, "_m_valid"},  32'(bus.m_valid), 32'd0);
        expect_eq({pfx, "_m_sop"},    32'(bus.m_sop),   32'd0);
        expect_eq({pfx, "_m_eop"},    32'(bus.m_eop),   32'd0);
        expect_eq({pfx, "_frame"},    32'(frame_cnt),   32'd0);
        expect_eq({pfx, "_err"},      32'(err_sop),     32'd0);
        expect_eq({pfx, "_busy"},     32'(busy),        32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.s_valid = 1'b0;
        bus.s_sop   = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;

        // Samples without sop in IDLE are dropped; flush in IDLE is ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, i == 2, 1'b0, 0, 1'b0, 0);
            expect_eq("idle_cnt",  32'(ctrl_cnt), 32'd0);
            expect_eq("idle_busy", 32'(busy),     32'd0);
        end

        // Frame A: 16 back-to-back samples.
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 1'b0, 1'b1, i, 1'b1, 0);
            expect_eq("a_cnt",  32'(ctrl_cnt), 32'((i + 1) % N));
            expect_eq("a_busy", 32'(busy),     32'd1);
        end
        expect_eq("a_frame", 32'(frame_cnt), 32'd1);

        // Frame B: every other cycle stalled.
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, 1'b0, 1'b1, i, 1'b1, 0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
            expect_eq("b_cnt", 32'(ctrl_cnt), 32'((i + 1) % N));
            expect_eq("b_err", 32'(err_sop),  32'd0);
        end
        expect_eq("b_frame", 32'(frame_cnt), 32'd2);
        expect_eq("b_state", 32'(dbg_state), 32'(RUN));

        // Misaligned sop after 7 samples: resync, orphaned tags lose sop/eop.
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b0, 1'b1, i, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 7);
        expect_eq("rs_cnt", 32'(ctrl_cnt), 32'd1);
        expect_eq("rs_err", 32'(err_sop),  32'd1);
        for (int i = 1; i < N; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, i, 1'b1, 0);
            if (i == 1) expect_eq("rs_err_end", 32'(err_sop), 32'd0);
        end
        expect_eq("rs_frame", 32'(frame_cnt), 32'd3);

        // Asynchronous reset mid-frame at ctrl_cnt 9.
        for (int i = 0; i < 9; i++) step(1'b1, i == 0, 1'b0, 1'b1, i, 1'b1, 0);
        expect_eq("pre_rst_cnt", 32'(ctrl_cnt), 32'd9);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_sop   = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_vals("arst");
        hist_idx.delete();
        exp_q.delete();
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Two continuous frames, flush requested mid-frame, then drain.
        mv_cnt = 0; ms_cnt = 0; me_cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            step(1'b1, (i % N) == 0, i == 20, 1'b1, i % N, 1'b1, 0);
            if (i == 15) expect_eq("f_frame1", 32'(frame_cnt), 32'd1);
            if (i == 20) expect_eq("f_deferred", 32'(dbg_state), 32'(RUN));
        end
        expect_eq("f_frame2", 32'(frame_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        expect_eq("fl_state",   32'(dbg_state),   32'(FLUSH));
        expect_eq("fl_s_ready", 32'(bus.s_ready), 32'd0);
        for (int j = 0; j < PL; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, j % N, 1'b0, 0);
            if (j < PL - 1) begin
                expect_eq("fl_in_zero", 32'(in_zero),     32'd1);
                expect_eq("fl_ready",   32'(bus.s_ready), 32'd0);
            end else begin
                expect_eq("fl_end_busy",  32'(busy),        32'd0);
                expect_eq("fl_end_ready", 32'(bus.s_ready), 32'd1);
                expect_eq("fl_end_zero",  32'(in_zero),     32'd0);
                expect_eq("fl_end_cnt",   32'(ctrl_cnt),    32'd0);
            end
        end
        expect_eq("fl_m_valid_n", 32'(mv_cnt), 32'd32);
        expect_eq("fl_m_sop_n",   32'(ms_cnt), 32'd2);
        expect_eq("fl_m_eop_n",   32'(me_cnt), 32'd2);

        // Back in IDLE: stays idle, latch cleared.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
            expect_eq("post_busy", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r22_fft_sched.md
Name: r22_fft_sched

Overview:
Sequencing controller for the radix-2^2 single-path delay-feedback FFT pipeline. It accepts a valid/ready sample stream with start-of-frame marking. It generates the shared log2(N) point counter, the global datapath enable, and the per-stage butterfly control bits, each delayed to match pipeline register latency. It also tags samples through the pipeline so results come out with valid/sop/eop, and it drains the last frame with zero injection on flush.

Parameters:
N_POINTS, 16, FFT size; power of 4.
BF_LAT, 1, register latency of one butterfly (BFI or BFII), in enable cycles.
TFM_LAT, 2, latency of twiddle ROM read plus multiply, in enable cycles.
PIPE_LAT, 18, enable cycles from sample accept to its result at the datapath output.
Derived localparams: LOG2N = clog2(N_POINTS); LOG4N = LOG2N/2; SLAT = 2*BF_LAT + TFM_LAT.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
s_valid  in  1  input sample valid
s_sop  in  1  input sample is frame index 0
s_ready  out  1  controller accepts sample
flush  in  1  request drain after the current frame
fft_en  out  1  global datapath enable
in_zero  out  1  datapath input mux selects 0+j0
ctrl_cnt  out  LOG2N  undelayed point counter, also the ROM address source
ctrl_bfi  out  LOG4N  per-stage BFI control bit
ctrl_bfii1  out  LOG4N  per-stage BFII control bit 1
ctrl_bfii2  out  LOG4N  per-stage BFII control bit 2
m_valid  out  1  datapath output holds a real result
m_sop  out  1  result is frame bin 0
m_eop  out  1  result is frame bin N-1
frame_cnt  out  16  completed input frames, wraps
err_sop  out  1  one-cycle pulse on misaligned sop
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; ctrl_cnt 0; all delay lines and tag line 0; frame_cnt 0; err_sop 0; flush latch 0.
- Reset values of outputs: s_ready 1, fft_en 0, in_zero 0, ctrl_* 0, m_* 0, busy 0.
- Reset mid-operation discards everything in flight. No partial frame is emitted.
- Accept = s_valid & s_ready.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - s_ready = 1.
  - s_valid without s_sop: the sample is dropped, no enable.
  - Accept with s_sop: the sample is index 0, fft_en = 1, go to RUN.
- RUN:
  - s_ready = 1; fft_en = s_valid.
  - No s_valid: the pipeline stalls; all delay and tag lines hold.
  - Each accept advances ctrl_cnt (modulo N).
  - Accept at ctrl_cnt == N-1: frame_cnt++.
  - s_sop accepted with ctrl_cnt != 0: err_sop pulses; the sample is taken as index 0 (ctrl_cnt resyncs). The partial frame's tags get sop/eop cleared.
  - flush sets a latch, so flush mid-frame is deferred.
  - Latch set and ctrl_cnt == 0 with no accept this cycle: go to FLUSH.
- FLUSH:
  - s_ready = 0; fft_en = 1 every cycle; in_zero = 1; ctrl_cnt keeps counting.
  - A drain counter runs PIPE_LAT cycles, then the state goes to IDLE with ctrl_cnt 0 and the latch cleared.
  - Flush asserted in IDLE: ignored.
- Control bits: the base bits are ctrl_cnt[LOG2N-1-2s] (BFI) and ctrl_cnt[LOG2N-2-2s] (BFII2).
  - Stage s BFI bit is delayed s*SLAT enables.
  - Stage s BFII bits are delayed s*SLAT + BF_LAT enables; BFII1 is the BFI base bit and BFII2 is the next bit.
  - Delay lines shift only when fft_en = 1.
  - Delay 0 means direct wiring.
- Tag line: PIPE_LAT entries of {real, sop, eop}, shifts on fft_en.
  - Input entry: real = accept, sop = (index 0), eop = (index N-1).
  - In FLUSH the input entry is all 0.
- Outputs (combinational from the tag tail):
  - m_valid = fft_en & tail.real.
  - m_sop = m_valid & tail.sop.
  - m_eop = m_valid & tail.eop.
- Results emerge in the datapath's natural bit-reversed order; reordering is out of scope.

Decomposition:
- Package r22_fft_pkg holds: state enum (IDLE/RUN/FLUSH), the tag struct {real, sop, eop}, and functions for clog2-based LOG4N and the stage delay (s*SLAT, +BF_LAT).
- One sub-module, r22_en_delay: parameterised-depth shift register with enable, width parameter, depth 0 as passthrough. It is instantiated for every control bit and for the tag line.

Test Plan:
1. Defaults; after reset, 16 back-to-back accepts with s_sop on the first -> fft_en high 16 cycles, ctrl_cnt 0..15, frame_cnt = 1; ctrl_bfi[1] equals ctrl_cnt[1] delayed 4 enables; ctrl_bfii1[0] equals ctrl_cnt[3] delayed 1 enable.
2. Frame with s_valid low on every other cycle -> fft_en mirrors s_valid; the delayed control bits and the tag line advance only on enabled cycles; m_valid never asserts in a stalled cycle.
3. Two continuous frames then flush -> after the last accept, FLUSH runs 18 cycles with in_zero = 1 and s_ready = 0. m_valid counts 32 total, m_sop twice, m_eop twice. Then IDLE, busy = 0.
4. s_valid without s_sop in IDLE for 5 cycles -> fft_en = 0, ctrl_cnt = 0. Next s_sop starts the frame.
5. s_sop at ctrl_cnt = 7 -> err_sop single pulse, ctrl_cnt = 1 next. The 7 prior samples emerge with m_valid = 1 and m_sop/m_eop = 0.
6. rst asserted at ctrl_cnt = 9 mid-RUN -> all outputs return to reset values asynchronously; no m_valid until a new sop frame fills 18 enables.
